bram_fifo_ctrl: RTL
===================

BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 11, RAM address width; DEPTH = 2**ADDR_W = 2048 words.
REQ-002 Parameter: DATA_W, default 8, RAM data width.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: flush  input  1  synchronous clear of all FIFO contents.
REQ-007 Port: in_valid  input  1  write request.
REQ-008 Port: in_data  input  DATA_W  write word.
REQ-009 Port: in_ready  output  1  high while the FIFO can accept a word.
REQ-010 Port: out_valid  output  1  head word present.
REQ-011 Port: out_data  output  DATA_W  head word.
REQ-012 Port: out_ready  input  1  consumer pops the head word.
REQ-013 Port: level  output  ADDR_W+1  words accepted and not yet popped (0..2048).
REQ-014 Port: ram_we  output  1  RAM write enable.
REQ-015 Port: ram_a  output  ADDR_W  RAM write address.
REQ-016 Port: ram_di  output  DATA_W  RAM write data.
REQ-017 Port: ram_dpra  output  ADDR_W  RAM read address.
REQ-018 Port: ram_dpo  input  DATA_W  RAM read data, registered by RAM one clock after ram_dpra.

Function
REQ-019 Push: in_valid & in_ready at an edge; ram_we = in_valid & in_ready, ram_a = wr_ptr, ram_di = in_data (combinational); wr_ptr increments mod DEPTH.
REQ-020 in_ready = !flush & (level != DEPTH); full state reached at level == 2048.
REQ-021 Pop: out_valid & out_ready at an edge; the head entry is removed.
REQ-022 Storage: RAM count (ram_cnt), one in-flight read flag, 2-entry output skid buffer; level = ram_cnt + in-flight + buffer occupancy.
REQ-023 Read issue: in a cycle where ram_cnt > 0 and (buffer occupancy + in-flight - pop this cycle) < 2; ram_dpra = rd_ptr; rd_ptr increments mod DEPTH; ram_cnt decrements; in-flight set.
REQ-024 A word written at edge E is counted in ram_cnt only after E; it is never read in the same cycle it is written (no read/write address collision on unwritten data).
REQ-025 In-flight read: ram_dpo is captured into the skid buffer at the next edge; the in-flight flag is cleared.
REQ-026 Latency: when the FIFO is empty, a word pushed at edge E gives out_valid = 1 and out_data = that word after edge E+2.
REQ-027 Throughput: with in_valid and out_ready held high in steady state, one word is pushed and one is popped every cycle with no bubbles.
REQ-028 Ordering: out_data sequence equals the in_data acceptance sequence, including across wr_ptr/rd_ptr wrap from 2047 to 0.
REQ-029 Simultaneous push and pop at level == DEPTH: the pop completes; the push is refused (in_ready is already low).
REQ-030 Simultaneous push and pop at level 0: the push is accepted; no pop occurs (out_valid is low).
REQ-031 Flush: at the flush edge, pointers, ram_cnt, buffer, in-flight and level go to 0; an in-flight read result is discarded; flush overrides a simultaneous push or pop.
REQ-032 The controller never asserts ram_we when level == DEPTH, and never pops when level == 0.

Reset
REQ-033 Reset overrides flush and all other inputs.
REQ-034 Reset: wr_ptr = rd_ptr = 0, ram_cnt = 0, buffer empty, in-flight = 0.
REQ-035 Outputs after the reset edge: in_ready = 0 while reset is high; out_valid = 0, out_data = 0, level = 0, ram_we = 0, ram_a = 0, ram_dpra = 0, ram_di = in_data.
REQ-036 Reset mid-operation (in-flight read pending) discards all data; the first push after reset is returned first.

Structure
REQ-037 Shared include holds FIFO_ADDR_W (11), FIFO_DATA_W (8) and FIFO_DEPTH (2048).
REQ-038 The skid buffer is one sub-module, fifo_skid2: a 2-entry register buffer with valid/ready and flush.
REQ-039 The RAM (bram_2k_8) is instantiated by the parent, outside this block.

Verification
REQ-040 After reset, push 0x41 at edge 0 -> out_valid and out_data = 0x41 after edge 2; level = 1 from edge 0 until the pop.
REQ-041 Push 2048 words 0x00..0xFF repeating with out_ready = 0 -> in_ready low at level 2048; the 2049th push is refused; drain yields the exact sequence.
REQ-042 Pre-fill 2000, then stream 500 words with in_valid = out_ready = 1 -> pointers wrap; 1 word per cycle; order preserved; level stays constant.
REQ-043 Random in_valid/out_ready toggling for 10k cycles -> scoreboard matches, level matches the model, ram_we is never asserted at full.
REQ-044 Flush with level = 37 and a read in flight -> level = 0, out_valid = 0 next cycle; a subsequent push of 0x5A is popped as 0x5A.
REQ-045 Reset asserted mid-stream for 1 cycle -> all outputs take their reset values; no stale word appears afterward.

Source files
------------

// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared sizing for the BRAM-backed FIFO controller and its output skid buffer.
package bram_fifo_ctrl_pkg;

    localparam int FIFO_ADDR_W = 11;
    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 2 ** FIFO_ADDR_W;

    typedef logic [1:0] skid_cnt_t;

endpackage

// File: rtl/bram_fifo_ctrl_skid2.sv
// fifo_skid2: two-entry register buffer; entry 0 is always the head word.
module fifo_skid2
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output skid_cnt_t         count_o
);

    skid_cnt_t         cnt_q, cnt_d;
    logic [DATA_W-1:0] e0_q, e0_d;
    logic [DATA_W-1:0] e1_q, e1_d;
    logic              pop;

    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = e0_q;
    assign count_o     = cnt_q;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        unique case ({in_valid_i, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = in_data_i;
                else               e1_d = in_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged: the new word lands behind whatever survives the pop.
                if (cnt_q == 2'd1) begin
                    e0_d = in_data_i;
                end else begin
                    e0_d = e1_q;
                    e1_d = in_data_i;
                end
            end
            default: ;
        endcase
        if (flush_i) cnt_d = 2'd0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM with a registered read port,
// hiding the read latency behind a two-entry output skid buffer.
module bram_fifo_ctrl
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_di,
    output logic [ADDR_W-1:0] ram_dpra,
    input  logic [DATA_W-1:0] ram_dpo
);

    localparam int             DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic              inflight_q, inflight_d;
    skid_cnt_t         skid_cnt;
    logic              push, pop, rd_issue;

    assign level    = ram_cnt_q + (ADDR_W + 1)'(inflight_q) + (ADDR_W + 1)'(skid_cnt);
    assign in_ready = !reset && !flush && (level != LEVEL_FULL);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    assign ram_we   = push;
    assign ram_a    = wr_ptr_q;
    assign ram_di   = in_data;
    assign ram_dpra = rd_ptr_q;

    // Issue a read only if the word will still have a skid slot when it returns.
    assign rd_issue = !flush && (ram_cnt_q != '0) &&
                      (({1'b0, skid_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{(ADDR_W-1){1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{(ADDR_W-1){1'b0}}, rd_issue};
        ram_cnt_d  = ram_cnt_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(rd_issue);
        inflight_d = rd_issue;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ram_cnt_d  = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    fifo_skid2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (flush),
        .in_valid_i  (inflight_q),
        .in_data_i   (ram_dpo),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .count_o     (skid_cnt)
    );

endmodule
